// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Data has priority; a streak limiter guarantees fetch progress and a watchdog bounds WAIT.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err
);
    localparam int              SW         = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [7:0]      TO_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        r_state;
    logic          r_own_d;
    logic [7:0]    r_tcnt;
    logic [SW-1:0] r_streak;

    logic          w_any_req;
    logic          w_pick_if;
    logic [SW-1:0] w_streak_nxt;

    assign w_any_req    = if_req | d_req;
    assign w_pick_if    = if_req & (~d_req | (r_streak == STREAK_MAX));
    // Streak only counts data grants that actually made a fetch wait.
    assign w_streak_nxt = !if_req                  ? '0 :
                          (r_streak == STREAK_MAX) ? r_streak : r_streak + SW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_own_d   <= 1'b0;
            r_tcnt    <= '0;
            r_streak  <= '0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            bus_err   <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            bus_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        mem_req <= 1'b1;
                        r_state <= S_ISSUE;
                        if (w_pick_if) begin
                            r_own_d   <= 1'b0;
                            if_gnt    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                            r_streak  <= '0;
                        end else begin
                            r_own_d   <= 1'b1;
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                            r_streak  <= w_streak_nxt;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A completion in the last allowed cycle still wins over the abort.
                    if (mem_rvalid) begin
                        r_state <= S_IDLE;
                        if (r_own_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_we ? '0 : mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else if (r_tcnt == TO_LAST) begin
                        r_state <= S_IDLE;
                        bus_err <= 1'b1;
                        if (r_own_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= '0;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model
// (arbitration rule, streak count, per-requester last read data, latency windows).
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TO   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we, mem_ready, mem_rvalid, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int          nvec = 0;
    int          nerr = 0;
    int          m_streak = 0;
    logic [31:0] m_if_rd = '0;
    logic [31:0] m_d_rd  = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAXS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] pulses();
        return {if_gnt, d_gnt, if_rvalid, d_rvalid, bus_err};
    endfunction

    function automatic logic [138:0] all_out();
        return {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err};
    endfunction

    // One complete transaction from an IDLE cycle; rv_dly >= TO means memory never answers.
    task automatic run_txn(input logic ireq, input logic [31:0] iaddr,
                           input logic dreq, input logic dwe, input logic [31:0] daddr,
                           input logic [31:0] dwdata, input logic [3:0] dbe,
                           input int rdy_dly, input int rv_dly, input logic [31:0] rdat,
                           output logic fwin);
        logic [68:0] held;
        logic [31:0] exp_rd;
        logic        tmo;
        if_req = ireq; if_addr = iaddr;
        d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata; d_be = dbe;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        fwin = ireq && (!dreq || m_streak == MAXS);
        tmo  = (rv_dly >= TO);
        step();
        chk("gnt", pulses(), fwin ? 5'b10000 : 5'b01000);
        chk("mem_req_issue", mem_req, 1);
        if (fwin) begin
            chk("fetch_fields", {mem_we, mem_addr}, {1'b0, iaddr});
            m_streak = 0;
            if_req = 1'b0;
        end else begin
            chk("data_fields", {mem_we, mem_addr, mem_wdata, mem_be}, {dwe, daddr, dwdata, dbe});
            m_streak = ireq ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            d_req = 1'b0;
        end
        held = {mem_we, mem_addr, mem_wdata, mem_be};
        for (int k = 0; k < rdy_dly; k++) begin
            step();
            chk("stall_pulses", pulses(), 0);
            chk("stall_hold", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, {1'b1, held});
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("wait_entry", {mem_req, pulses()}, 0);
        exp_rd = (fwin || !dwe) ? rdat : 32'h0;
        if (!tmo) begin
            for (int k = 0; k < rv_dly; k++) begin
                mem_rdata = $urandom;
                step();
                chk("wait_quiet", {mem_req, pulses()}, 0);
            end
            mem_rvalid = 1'b1; mem_rdata = rdat;
            step();
            mem_rvalid = 1'b0; mem_rdata = $urandom;
        end else begin
            for (int k = 1; k < TO; k++) begin
                step();
                chk("wd_quiet", {mem_req, pulses()}, 0);
            end
            step();
            exp_rd = 32'h0;
        end
        if (fwin) m_if_rd = exp_rd; else m_d_rd = exp_rd;
        chk("resp_pulses", pulses(), {2'b00, fwin, !fwin, tmo});
        chk("resp_data", {if_rdata, d_rdata}, {m_if_rd, m_d_rd});
        if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        logic        f;
        logic [9:0]  seq;
        logic        ir, dr;
        int          sel, rv;
        reset = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        step(); step();
        chk("reset_outputs", all_out(), 0);
        reset = 1'b1;
        step();
        chk("idle_after_reset", all_out(), 0);

        // single fetch: gnt cycle 1, rvalid cycle 3
        run_txn(1'b1, 32'h0000_0010, 1'b0, 1'b0, 0, 0, 0, 0, 0, 32'h0050_0093, f);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);

        // store: d_rdata must be 0, fetch side quiet
        run_txn(1'b0, 0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111, 0, 0, 32'h1234_5678, f);
        chk("store_rdata", {d_rdata, if_rdata}, {32'h0, 32'h0050_0093});

        // both requesters held continuously
        for (int i = 0; i < 10; i++) begin
            run_txn(1'b1, 32'h2000 + 32'(i * 4), 1'b1, 1'b0, 32'h3000 + 32'(i * 4),
                    32'h0, 4'hF, 0, 0, $urandom, f);
            seq[i] = f;
        end
        chk("grant_seq", seq, 10'b10_0001_0000);

        // stalled memory
        run_txn(1'b0, 0, 1'b1, 1'b0, 32'h440, 32'h0, 4'h3, 5, 1, 32'hCAFE_0001, f);

        // watchdog on a fetch, late rvalid ignored, then normal traffic
        run_txn(1'b1, 32'h80, 1'b0, 1'b0, 0, 0, 0, 0, TO, 32'hFFFF_FFFF, f);
        chk("wd_if_rdata", if_rdata, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        chk("late_rvalid_ignored", {mem_req, pulses()}, 0);
        run_txn(1'b0, 0, 1'b1, 1'b0, 32'h88, 0, 4'hF, 0, TO - 1, 32'h0BAD_F00D, f);

        // reset while in WAIT
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
        step();
        chk("rst_txn_gnt", pulses(), 5'b01000);
        d_req = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs", all_out(), 0);
        m_streak = 0; m_if_rd = 0; m_d_rd = 0;
        step();
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_rvalid = 1'b0;
        chk("no_rvalid_after_reset", all_out(), 0);
        step();
        chk("still_idle_after_reset", all_out(), 0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(3, 0);
            ir  = (sel != 1);
            dr  = (sel != 0);
            rv  = ($urandom_range(9, 0) == 0) ? TO : $urandom_range(TO - 1, 0);
            run_txn(ir, $urandom, dr, 1'($urandom_range(1, 0)), $urandom, $urandom,
                    4'($urandom_range(15, 0)), $urandom_range(3, 0), rv, $urandom, f);
            if ($urandom_range(3, 0) == 0) begin
                step();
                chk("idle_gap", {mem_req, pulses()}, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
